// File: rtl/vga_sprite_engine.sv
// VGA timing generator with a multi-sprite renderer and grid overlay.
// Two-stage pipeline: hit test plus bitmap row read, then priority, palette and overlay.
module vga_sprite_engine #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_ACTIVE = 1,
    parameter int NUM_SPRITES = 2,
    parameter int SPRITE_SIZE = 32,
    parameter int BPP         = 2,
    parameter int GRID_SIZE   = 32,
    parameter int GRID_EN     = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [10*NUM_SPRITES-1:0]         sprite_x,
    input  logic [10*NUM_SPRITES-1:0]         sprite_y,
    input  logic [NUM_SPRITES-1:0]            sprite_en,
    input  logic                              bmp_we,
    input  logic [2:0]                        bmp_sel,
    input  logic [$clog2(SPRITE_SIZE)-1:0]    bmp_row,
    input  logic [SPRITE_SIZE*BPP-1:0]        bmp_data,
    input  logic                              pal_we,
    input  logic [3+BPP-1:0]                  pal_addr,
    input  logic [8:0]                        pal_data,
    output logic [2:0]                        red,
    output logic [2:0]                        green,
    output logic [2:0]                        blue,
    output logic                              hsync,
    output logic                              vsync,
    output logic                              frame_start,
    output logic                              display_active
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int ROW_W    = $clog2(SPRITE_SIZE);
    localparam int GRID_W   = $clog2(GRID_SIZE);
    localparam int ROW_BITS = SPRITE_SIZE * BPP;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS     = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS     = 11'(V_DISPLAY);
    localparam logic [10:0] HS_BEGIN  = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEGIN  = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [10:0] SPR_EDGE  = 11'(SPRITE_SIZE);
    localparam logic        SYNC_ON   = (SYNC_ACTIVE != 0);
    localparam logic        SYNC_OFF  = (SYNC_ACTIVE == 0);
    localparam logic        GRID_ON   = (GRID_EN != 0);

    // ---------------- raster counters ----------------
    logic [10:0] h_cnt_reg;
    logic [10:0] v_cnt_reg;
    logic        frame_end;

    assign frame_end = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? 11'd0 : v_cnt_reg + 11'd1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 11'd1;
        end
    end

    // Positions are sampled only on the last cycle of a frame so a frame never tears.
    logic [10*NUM_SPRITES-1:0] x_sh_reg;
    logic [10*NUM_SPRITES-1:0] y_sh_reg;
    logic [NUM_SPRITES-1:0]    en_sh_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_sh_reg  <= '0;
            y_sh_reg  <= '0;
            en_sh_reg <= '0;
        end else if (frame_end) begin
            x_sh_reg  <= sprite_x;
            y_sh_reg  <= sprite_y;
            en_sh_reg <= sprite_en;
        end
    end

    // ---------------- stage 1: raster-wide flags ----------------
    logic vis_s1_reg;
    logic hs_s1_reg;
    logic vs_s1_reg;
    logic fs_s1_reg;
    logic grid_s1_reg;
    logic grid_next;

    assign grid_next = GRID_ON && ((h_cnt_reg[GRID_W-1:0] == '0) || (v_cnt_reg[GRID_W-1:0] == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vis_s1_reg  <= 1'b0;
            hs_s1_reg   <= 1'b0;
            vs_s1_reg   <= 1'b0;
            fs_s1_reg   <= 1'b0;
            grid_s1_reg <= 1'b0;
        end else begin
            vis_s1_reg  <= (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
            hs_s1_reg   <= (h_cnt_reg >= HS_BEGIN) && (h_cnt_reg < HS_END);
            vs_s1_reg   <= (v_cnt_reg >= VS_BEGIN) && (v_cnt_reg < VS_END);
            fs_s1_reg   <= (h_cnt_reg == 11'd0) && (v_cnt_reg == 11'd0);
            grid_s1_reg <= grid_next;
        end
    end

    // ---------------- per-sprite hit test and bitmap read ----------------
    logic [NUM_SPRITES-1:0]     opaque;
    logic [NUM_SPRITES*BPP-1:0] code_all;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
            logic [ROW_BITS-1:0] bmp_mem [SPRITE_SIZE];
            logic [ROW_BITS-1:0] row_reg;
            logic [ROW_W-1:0]    col_reg;
            logic                hit_reg;
            logic [10:0]         x_ext;
            logic [10:0]         y_ext;
            logic [10:0]         dx;
            logic [10:0]         dy;
            logic                hit_next;
            logic [BPP-1:0]      pix_code;

            assign x_ext = {1'b0, x_sh_reg[gi*10 +: 10]};
            assign y_ext = {1'b0, y_sh_reg[gi*10 +: 10]};
            assign dx    = h_cnt_reg - x_ext;
            assign dy    = v_cnt_reg - y_ext;
            // Offsets are only trusted after the >= guards, so no coordinate wraps.
            assign hit_next = en_sh_reg[gi]
                              && (h_cnt_reg >= x_ext) && (dx < SPR_EDGE)
                              && (v_cnt_reg >= y_ext) && (dy < SPR_EDGE);

            // A write colliding with this cycle's read leaves the old row on row_reg.
            always_ff @(posedge clk) begin
                if (bmp_we && (bmp_sel == 3'(gi))) begin
                    bmp_mem[bmp_row] <= bmp_data;
                end
                row_reg <= bmp_mem[dy[ROW_W-1:0]];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hit_reg <= 1'b0;
                    col_reg <= '0;
                end else begin
                    hit_reg <= hit_next;
                    col_reg <= dx[ROW_W-1:0];
                end
            end

            assign pix_code                = row_reg[int'(col_reg)*BPP +: BPP];
            assign code_all[gi*BPP +: BPP] = pix_code;
            assign opaque[gi]              = hit_reg && (pix_code != '0);
        end
    endgenerate

    // ---------------- stage 2: priority, palette, overlay ----------------
    logic [8:0]     pal_mem [8 << BPP];
    logic           win_found;
    logic [2:0]     win_idx;
    logic [BPP-1:0] win_code;
    logic [8:0]     pal_rd;
    logic [8:0]     pixel_next;

    always_ff @(posedge clk) begin
        if (pal_we) begin
            pal_mem[pal_addr] <= pal_data;
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_code  = '0;
        // Scan downward so the lowest opaque index is the last assignment.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
                win_code  = code_all[i*BPP +: BPP];
            end
        end
    end

    assign pal_rd = pal_mem[{win_idx, win_code}];

    always_comb begin
        pixel_next = 9'd0;
        if (vis_s1_reg) begin
            if (grid_s1_reg) begin
                pixel_next = 9'h1FF;
            end else if (win_found) begin
                pixel_next = pal_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            red            <= 3'd0;
            green          <= 3'd0;
            blue           <= 3'd0;
            hsync          <= SYNC_OFF;
            vsync          <= SYNC_OFF;
            frame_start    <= 1'b0;
            display_active <= 1'b0;
        end else begin
            red            <= pixel_next[8:6];
            green          <= pixel_next[5:3];
            blue           <= pixel_next[2:0];
            hsync          <= hs_s1_reg ? SYNC_ON : SYNC_OFF;
            vsync          <= vs_s1_reg ? SYNC_ON : SYNC_OFF;
            frame_start    <= fs_s1_reg;
            display_active <= vis_s1_reg;
        end
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Scoreboard bench for vga_sprite_engine on a shrunken raster (80x56 total, 64x48 visible).
// Expected pixels are queued by the stimulus; a monitor tracks raster position and compares.
module tb_vga_sprite_engine;

    localparam int HD = 64, HF = 4, HSW = 8, HB = 4;
    localparam int VD = 48, VF = 2, VSW = 2, VB = 4;
    localparam int HT = HD + HF + HSW + HB;
    localparam int VT = VD + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int NS = 2, SS = 8, BPP = 2, GS = 16;
    localparam logic SA = 1'b0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [10*NS-1:0] sprite_x = '0;
    logic [10*NS-1:0] sprite_y = '0;
    logic [NS-1:0]    sprite_en = '0;
    logic             bmp_we = 1'b0;
    logic [2:0]       bmp_sel = '0;
    logic [2:0]       bmp_row = '0;
    logic [SS*BPP-1:0] bmp_data = '0;
    logic             pal_we = 1'b0;
    logic [3+BPP-1:0] pal_addr = '0;
    logic [8:0]       pal_data = '0;
    logic [2:0]       red, green, blue;
    logic             hsync, vsync, frame_start, display_active;

    vga_sprite_engine #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .SYNC_ACTIVE(0), .NUM_SPRITES(NS), .SPRITE_SIZE(SS), .BPP(BPP),
        .GRID_SIZE(GS), .GRID_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .bmp_we(bmp_we), .bmp_sel(bmp_sel), .bmp_row(bmp_row), .bmp_data(bmp_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
        .display_active(display_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         f;
        int         x;
        int         y;
        logic [8:0] rgb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Raster model: counter position and the two pipeline stages behind it.
    int    mf = 0, mh = 0, mv = 0;
    bit    in_rst = 1'b0, started = 1'b0;
    bit    p1_ok = 1'b0, p2_ok = 1'b0;
    int    p1_f = 0, p1_x = 0, p1_y = 0;
    int    p2_f = 0, p2_x = 0, p2_y = 0;
    longint cyc = 0;
    longint last_fs = -1;

    task automatic fail(input string msg);
        failures++;
        $display("FAIL %s", msg);
        if (failures >= 200) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    endtask

    task automatic push(input int f, input int x, input int y, input logic [8:0] rgb);
        exp_t e;
        e.f = f; e.x = x; e.y = y; e.rgb = rgb;
        q.push_back(e);
    endtask

    function automatic bit is_before(input exp_t e, input int f, input int x, input int y);
        return (e.f < f) || (e.f == f && (e.y < y || (e.y == y && e.x < x)));
    endfunction

    task automatic check_cycle();
        logic [3:0] exp_t4;
        logic [3:0] got_t4;
        bit         hs_e, vs_e, de_e, fs_e;
        exp_t       e;
        hs_e = p2_ok && p2_x >= HD + HF && p2_x < HD + HF + HSW;
        vs_e = p2_ok && p2_y >= VD + VF && p2_y < VD + VF + VSW;
        de_e = p2_ok && p2_x < HD && p2_y < VD;
        fs_e = p2_ok && p2_x == 0 && p2_y == 0;
        exp_t4 = {hs_e ? SA : ~SA, vs_e ? SA : ~SA, de_e, fs_e};
        got_t4 = {hsync, vsync, display_active, frame_start};
        checks++;
        if (got_t4 !== exp_t4)
            fail($sformatf("timing cyc=%0d pos=(%0d,%0d) got hs/vs/de/fs=%b expected %b",
                           cyc, p2_x, p2_y, got_t4, exp_t4));
        if (!de_e) begin
            checks++;
            if ({red, green, blue} !== 9'd0)
                fail($sformatf("blank_rgb cyc=%0d pos=(%0d,%0d) got %03o expected 000",
                               cyc, p2_x, p2_y, {red, green, blue}));
        end
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
                checks++;
                if (cyc - last_fs != FRAME)
                    fail($sformatf("frame_period got %0d expected %0d", cyc - last_fs, FRAME));
            end
            last_fs = cyc;
        end
        if (p2_ok) begin
            while (q.size() > 0 && is_before(q[0], p2_f, p2_x, p2_y)) begin
                e = q.pop_front();
                checks++;
                fail($sformatf("pixel_missed f=%0d (%0d,%0d) got nothing expected %03o",
                               e.f, e.x, e.y, e.rgb));
            end
            if (q.size() > 0 && q[0].f == p2_f && q[0].x == p2_x && q[0].y == p2_y) begin
                e = q.pop_front();
                checks++;
                if ({red, green, blue} !== e.rgb)
                    fail($sformatf("pixel f=%0d (%0d,%0d) got %03o expected %03o",
                                   e.f, e.x, e.y, {red, green, blue}, e.rgb));
                else
                    $display("pixel f=%0d (%0d,%0d) rgb=%03o ok", e.f, e.x, e.y, e.rgb);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                if (!in_rst) mf++;
                in_rst  = 1'b1;
                started = 1'b1;
                mh = 0; mv = 0;
                p1_ok = 1'b0; p2_ok = 1'b0;
                last_fs = -1;
            end else begin
                in_rst = 1'b0;
                p2_ok = p1_ok; p2_f = p1_f; p2_x = p1_x; p2_y = p1_y;
                p1_ok = 1'b1;  p1_f = mf;   p1_x = mh;   p1_y = mv;
                if (mh == HT - 1) begin
                    mh = 0;
                    if (mv == VT - 1) begin
                        mv = 0;
                        mf++;
                    end else begin
                        mv++;
                    end
                end else begin
                    mh++;
                end
            end
            @(negedge clk);
            if (started) check_cycle();
        end
    end

    task automatic wait_at(input int f, input int x, input int y);
        int n;
        n = 0;
        while (!(mf == f && mh == x && mv == y)) begin
            @(negedge clk);
            n++;
            if (n > 20000) begin
                checks++;
                fail($sformatf("wait_timeout at f=%0d (%0d,%0d) got f=%0d (%0d,%0d) expected reached",
                               f, x, y, mf, mh, mv));
                return;
            end
        end
    endtask

    task automatic bmp_write(input int sel, input int row, input logic [15:0] data);
        bmp_we = 1'b1; bmp_sel = 3'(sel); bmp_row = 3'(row); bmp_data = data;
        @(negedge clk);
        bmp_we = 1'b0;
    endtask

    task automatic pal_write(input int s, input int c, input logic [8:0] data);
        pal_we = 1'b1; pal_addr = {3'(s), 2'(c)}; pal_data = data;
        @(negedge clk);
        pal_we = 1'b0;
    endtask

    task automatic set_spr(input int n, input int x, input int y);
        sprite_x[n*10 +: 10] = 10'(x);
        sprite_y[n*10 +: 10] = 10'(y);
    endtask

    initial begin : stimulus
        repeat (5) @(negedge clk);
        // Frame 1: no sprites shown, grid only.
        push(1, 0, 0, 9'o777);  push(1, 5, 0, 9'o777);  push(1, 5, 5, 9'o000);
        push(1, 16, 5, 9'o777); push(1, 5, 32, 9'o777); push(1, 63, 47, 9'o000);
        rst_n = 1'b1;

        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 8; r++)
                bmp_write(s, r, (s == 0 && r == 7) ? 16'h5550 : 16'h5555);
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 4; c++)
                pal_write(s, c, (s == 0 && c == 1) ? 9'o700 :
                                (s == 0 && c == 2) ? 9'o007 :
                                (s == 1 && c == 1) ? 9'o070 : 9'o000);

        // Frame 2: sprite 0 at (12,20), sprite 1 at (36,36).
        set_spr(0, 12, 20); set_spr(1, 36, 36); sprite_en = 2'b11;
        push(2, 12, 20, 9'o700); push(2, 11, 21, 9'o000); push(2, 13, 21, 9'o700);
        push(2, 16, 21, 9'o777); push(2, 20, 21, 9'o000); push(2, 19, 27, 9'o700);
        push(2, 12, 28, 9'o000); push(2, 37, 37, 9'o070); push(2, 44, 37, 9'o000);

        // Move sprite 0 mid-frame; overlap shows from frame 3 with sprite 0 on top.
        wait_at(2, 0, 10);
        set_spr(0, 36, 36);
        push(3, 13, 21, 9'o000); push(3, 37, 37, 9'o700); push(3, 37, 42, 9'o700);
        push(3, 36, 43, 9'o070); push(3, 38, 43, 9'o700);

        // Drop sprite 0 mid-frame; sprite 1 shows through from frame 4.
        wait_at(3, 0, 40);
        sprite_en = 2'b10;
        push(4, 37, 37, 9'o070); push(4, 37, 42, 9'o070);
        push(4, 36, 43, 9'o070); push(4, 38, 43, 9'o070);

        // Frame 5: right-edge clip and live bitmap rewrite.
        wait_at(4, 0, 5);
        set_spr(0, 60, 10); set_spr(1, 40, 24); sprite_en = 2'b11;
        wait_at(5, 0, 5);
        bmp_write(0, 3, 16'hAAAA);
        bmp_write(7, 4, 16'h0000);
        push(5, 60, 11, 9'o700); push(5, 63, 11, 9'o700); push(5, 1, 12, 9'o000);
        push(5, 61, 12, 9'o700); push(5, 61, 13, 9'o007); push(5, 61, 14, 9'o700);
        push(5, 61, 17, 9'o000); push(5, 62, 17, 9'o700); push(5, 41, 28, 9'o070);
        push(5, 47, 31, 9'o070);

        // Frame 6: far-right sprite must not wrap; bottom clip.
        set_spr(0, 1020, 24); set_spr(1, 30, 44);
        push(6, 0, 25, 9'o777);  push(6, 1, 25, 9'o000); push(6, 3, 25, 9'o000);
        push(6, 1, 27, 9'o000);  push(6, 31, 44, 9'o070); push(6, 37, 47, 9'o070);

        // Mid-frame reset: raster restarts and shadows clear.
        wait_at(7, 30, 20);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        push(8, 0, 0, 9'o777); push(8, 5, 5, 9'o000);
        push(8, 31, 45, 9'o000); push(8, 5, 47, 9'o000);
        rst_n = 1'b1;

        wait_at(9, 0, 2);
        checks++;
        if (q.size() != 0)
            fail($sformatf("queue_drain got %0d pending expected 0", q.size()));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
- Parametrised VGA timing generator plus multi-sprite renderer; drives the board VGA pins directly.
- Supports NUM_SPRITES independently positioned, runtime-loadable sprites (BPP bits/pixel, per-sprite palette), a tiled grid overlay, tear-free position latching and registered, sync-aligned outputs.
- Game logic feeds positions; a loader writes bitmaps and palettes through simple write ports.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- SYNC_ACTIVE, 1, active level of hsync/vsync
- NUM_SPRITES, 2, sprite count (1..8)
- SPRITE_SIZE, 32, sprite edge in pixels (power of two)
- BPP, 2, bits per sprite pixel; code 0 is transparent
- GRID_SIZE, 32, grid pitch (power of two)
- GRID_EN, 1, enables grid overlay

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- sprite_x  in  10*NUM_SPRITES  sprite n left edge at [n*10 +: 10]
- sprite_y  in  10*NUM_SPRITES  sprite n top edge at [n*10 +: 10]
- sprite_en  in  NUM_SPRITES  per-sprite visibility
- bmp_we  in  1  bitmap row write strobe
- bmp_sel  in  3  sprite index for write
- bmp_row  in  log2(SPRITE_SIZE)  row index for write
- bmp_data  in  SPRITE_SIZE*BPP  row data; pixel i at [i*BPP +: BPP], i=0 leftmost
- pal_we  in  1  palette write strobe
- pal_addr  in  3+BPP  {sprite index, pixel code}
- pal_data  in  9  {r[2:0], g[2:0], b[2:0]}
- red, green, blue  out  3 each  colour outputs
- hsync, vsync  out  1 each  sync outputs
- frame_start  out  1  one-cycle pulse, first pixel of a frame
- display_active  out  1  high while output pixel is visible

Behaviour:
- Reset (rst_n low at clk edge): h/v counters 0; red/green/blue 0; hsync/vsync at inactive level (!SYNC_ACTIVE); frame_start 0; display_active 0; shadow positions/enables 0; pipeline cleared. Bitmap and palette RAMs are not reset. Reset mid-frame restarts at h=0, v=0 on the cycle after release.
- Counters: h wraps at H_TOTAL-1 (sum of H params) and increments v; v wraps at V_TOTAL-1. Counters are 11 bits wide.
- Sync raw: hsync active for H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC; vsync likewise on v.
- Shadowing: sprite_x, sprite_y and sprite_en are copied into shadow registers on the cycle where h=H_TOTAL-1 and v=V_TOTAL-1. Rendering uses only the shadows, so mid-frame position changes take effect next frame.
- Pipeline: total 2-cycle latency from counter value to all outputs.
  - Stage 1: per-sprite hit test uses 11-bit arithmetic, no wrap: x <= h < x+SPRITE_SIZE and y <= v < y+SPRITE_SIZE. Sprites extending beyond 1023 or the visible edge are clipped. On a hit, read the bitmap row and extract the BPP code at column h-x.
  - Stage 2: lowest-index enabled sprite with a non-zero code wins. Palette lookup yields the colour. Grid overrides (all 7s) when GRID_EN and (h mod GRID_SIZE=0 or v mod GRID_SIZE=0). Outside the visible area the output is forced to 0.
- hsync, vsync and display_active are delayed 2 cycles to stay aligned with RGB. frame_start is asserted with the output of pixel (0,0).
- RAM collisions: a write to a row or palette entry read in the same cycle returns old data. A write with bmp_sel >= NUM_SPRITES is ignored.
- Palette reset contents are undefined; the loader must program palettes before enabling sprites.

Test Plan:
- Reset held 5 cycles, then released -> RGB=0, sync inactive during reset; first hsync asserts when the output corresponds to h=656, lasts 96 cycles; line period 800; vsync 2 lines; frame period 420000 cycles; frame_start period 420000.
- Sprite 0 at (64,64), all rows 0x5555... (code 1), palette {0,1}=9'o700 -> pixel (65,65) red=7, green=0, blue=0; pixel (64,64) white from the grid; pixel (100,65) black.
- Sprites 0 and 1 both at (128,96), both opaque, different palettes -> sprite 0 colour shown; clear sprite_en[0] -> sprite 1 colour from the next frame.
- sprite_x changed mid-frame at v=200 -> current frame unchanged, new position appears on the next frame.
- Sprite at x=630 -> columns 630..639 drawn, nothing wraps to x=0..21 of the next line; sprite at y=470 is clipped at line 479.
- bmp_we to row 3 during active display -> row updates without glitching other rows; bmp_sel=7 with NUM_SPRITES=2 -> no change.
